// File: rtl/pc_nzp_pkg.sv
// Shared types and constants for the per-lane PC/NZP bank.
package pc_nzp_pkg;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } nzp_t;

   localparam logic [2:0] NZP_N = 3'b100;
   localparam logic [2:0] NZP_Z = 3'b010;
   localparam logic [2:0] NZP_P = 3'b001;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/nzp_compare.sv
// Combinational signed compare of one lane's operands into a one-hot NZP flag.
module nzp_compare
   import pc_nzp_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output nzp_t                  nzp_o
);

   // One extra bit keeps the difference exact for any pair of operands.
   logic signed [DATA_WIDTH:0] diff;

   assign diff = $signed({a_i[DATA_WIDTH-1], a_i}) - $signed({b_i[DATA_WIDTH-1], b_i});

   always_comb begin
      nzp_o   = '0;
      nzp_o.n = diff[DATA_WIDTH];
      nzp_o.z = (diff == '0);
      nzp_o.p = !diff[DATA_WIDTH] && (diff != '0);
   end

endmodule

// File: rtl/pc_nzp_bank.sv
// Per-lane PC and NZP flag bank with an IDLE/EVAL/COMMIT next-PC handshake.
// Define PC_WRAP_TRAP_EN to hold all-ones PCs and raise a sticky PC_OVF instead of wrapping.
module pc_nzp_bank
   import pc_nzp_pkg::*;
#(
   parameter int         NUM_THREADS = 4,
   parameter int         PC_WIDTH    = 8,
   parameter int         DATA_WIDTH  = 8,
   parameter logic [2:0] RESET_NZP   = 3'b010,
   parameter int         RESET_PC    = 0
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_THREADS-1:0]          thread_en_i,
   input  logic                            cmp_valid_i,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] cmp_a_i,
   input  logic [NUM_THREADS*DATA_WIDTH-1:0] cmp_b_i,
   input  logic                            pc_update_i,
   input  logic                            branch_i,
   input  logic [2:0]                      br_mask_i,
   input  logic [PC_WIDTH-1:0]             br_target_i,
   output logic                            ready_o,
   output logic                            update_done_o,
   output logic [NUM_THREADS*PC_WIDTH-1:0] pc_o,
   output logic [NUM_THREADS*3-1:0]        nzp_o,
   output logic                            diverged_o,
   output logic                            pc_ovf_o
);

   state_t                 state_q, state_d;
   logic                   ready, in_commit;
   logic                   accept_cmp, accept_pc;

   logic                   br_q;
   logic [2:0]             mask_q;
   logic [PC_WIDTH-1:0]    target_q;
   logic [NUM_THREADS-1:0] en_q;
   logic [NUM_THREADS-1:0] taken_q, taken_d;
   logic [NUM_THREADS-1:0] active_taken;
   logic                   div_q, div_d;

   nzp_t                   nzp_q   [NUM_THREADS];
   nzp_t                   cmp_nzp [NUM_THREADS];
   logic [PC_WIDTH-1:0]    pc_q    [NUM_THREADS];
   logic [PC_WIDTH-1:0]    pc_d    [NUM_THREADS];

   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      in_commit = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (pc_update_i) state_d = EVAL;
         end
         EVAL:   state_d = COMMIT;
         COMMIT: begin
            in_commit = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   assign accept_cmp = cmp_valid_i && ready;
   assign accept_pc  = pc_update_i && ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         br_q     <= 1'b0;
         mask_q   <= '0;
         target_q <= '0;
         en_q     <= '0;
         taken_q  <= '0;
         div_q    <= 1'b0;
      end else begin
         if (accept_pc) begin
            br_q     <= branch_i;
            mask_q   <= br_mask_i;
            target_q <= br_target_i;
            en_q     <= thread_en_i;
         end
         if (state_q == EVAL) taken_q <= taken_d;
         if (in_commit)       div_q   <= div_d;
      end
   end

   // Divergence only counts lanes that were active for this update.
   assign active_taken = taken_q & en_q;
   assign div_d        = br_q && (|active_taken) && (active_taken != en_q);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
         nzp_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
            .a_i   (cmp_a_i[gi*DATA_WIDTH +: DATA_WIDTH]),
            .b_i   (cmp_b_i[gi*DATA_WIDTH +: DATA_WIDTH]),
            .nzp_o (cmp_nzp[gi])
         );

         assign taken_d[gi] = br_q && (|(nzp_q[gi] & mask_q));

`ifdef PC_WRAP_TRAP_EN
         assign pc_d[gi] = (!in_commit || !en_q[gi]) ? pc_q[gi] :
                           taken_q[gi]               ? target_q :
                           (&pc_q[gi])               ? pc_q[gi] :
                                                       pc_q[gi] + 1'b1;
`else
         assign pc_d[gi] = (!in_commit || !en_q[gi]) ? pc_q[gi] :
                           taken_q[gi]               ? target_q :
                                                       pc_q[gi] + 1'b1;
`endif

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               nzp_q[gi] <= nzp_t'(RESET_NZP);
               pc_q[gi]  <= PC_WIDTH'(RESET_PC);
            end else begin
               if (accept_cmp && thread_en_i[gi]) nzp_q[gi] <= cmp_nzp[gi];
               pc_q[gi] <= pc_d[gi];
            end
         end

         assign pc_o[gi*PC_WIDTH +: PC_WIDTH] = pc_q[gi];
         assign nzp_o[gi*3 +: 3]              = nzp_q[gi];
      end
   endgenerate

`ifdef PC_WRAP_TRAP_EN
   logic [NUM_THREADS-1:0] wrap_hit;
   logic                   ovf_q;

   for (gi = 0; gi < NUM_THREADS; gi++) begin : g_wrap
      assign wrap_hit[gi] = in_commit && en_q[gi] && !taken_q[gi] && (&pc_q[gi]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          ovf_q <= 1'b0;
      else if (|wrap_hit)   ovf_q <= 1'b1;
   end

   assign pc_ovf_o = ovf_q;
`else
   assign pc_ovf_o = 1'b0;
`endif

   assign ready_o       = ready;
   assign update_done_o = in_commit;
   assign diverged_o    = div_q;

endmodule
